sdram_responder: RTL and testbench
==================================

SDRAM_RESPONDER -- requirements
Module: sdram_responder

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 14; number of low sdram_addr bits decoding the backing array (2**ADDR_BITS 32-bit words).
REQ-002 SHALL have parameter LATENCY, default 2, legal 1..15; cycles from request acceptance to done.
REQ-003 SHALL have parameter REFRESH_INTERVAL, default 780; cycles between refresh requests; 0 disables refresh.
REQ-004 SHALL have parameter REFRESH_CYCLES, default 4, legal 1..15; length of one refresh burst.
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 reset  in  1  synchronous, active-low (0 = reset), sampled on clk rising edge.
REQ-007 sdram_req  in  1  request strobe from bus interface.
REQ-008 sdram_write  in  1  1 = write, 0 = read; qualified by acceptance.
REQ-009 sdram_addr  in  22  word address; bits above ADDR_BITS-1 ignored (aliasing).
REQ-010 sdram_data_cpu2rc  in  32  write data.
REQ-011 sdram_ready  out  1  responder can accept a request this cycle.
REQ-012 sdram_done  out  1  one-cycle completion pulse.
REQ-013 sdram_data_rc2cpu  out  32  read data.

Function
REQ-014 States SHALL be IDLE, BUSY, DONE, REFRESH.
REQ-015 sdram_ready SHALL equal (state==IDLE) AND NOT refresh_pending, combinationally.
REQ-016 A request SHALL be accepted in a cycle where sdram_req=1 and sdram_ready=1; addr, write, data captured at that edge.
REQ-017 Acceptance SHALL move IDLE->DONE if LATENCY=1, else IDLE->BUSY with countdown LATENCY-1.
REQ-018 BUSY SHALL decrement each cycle and move to DONE on the cycle count reaches 1.
REQ-019 For acceptance in cycle T, sdram_done SHALL be 1 in exactly cycle T+LATENCY and 0 in all other cycles.
REQ-020 Write: array[addr[ADDR_BITS-1:0]] SHALL update at the edge entering DONE.
REQ-021 Read: sdram_data_rc2cpu SHALL load array contents at the edge entering DONE, be valid during DONE, and hold until the next read completes; writes SHALL NOT change it.
REQ-022 DONE SHALL last one cycle then go to IDLE (or REFRESH if refresh_pending).
REQ-023 sdram_req held high through DONE SHALL be treated as a new request, accepted no earlier than the cycle after DONE.
REQ-024 Refresh counter SHALL count every cycle 0..REFRESH_INTERVAL-1 and wrap; at wrap refresh_pending SHALL set.
REQ-025 In IDLE with refresh_pending=1, SHALL enter REFRESH for REFRESH_CYCLES cycles, clear refresh_pending on entry, then return to IDLE.
REQ-026 Refresh due while BUSY/DONE SHALL be deferred, not lost; serviced directly after DONE.
REQ-027 Refresh becoming pending in same cycle as sdram_req in IDLE: pending sets at the edge, so the request is accepted that cycle (ready was 1); refresh follows its DONE.
REQ-028 A second wrap while refresh already pending SHALL NOT queue an extra refresh.
REQ-029 Accepted requests SHALL never be dropped or reordered; one outstanding request maximum.
REQ-030 With REFRESH_INTERVAL=0, REFRESH SHALL be unreachable and refresh_pending constant 0.

Reset
REQ-031 reset=0 SHALL force state IDLE, countdown 0, refresh counter 0, refresh_pending 0, sdram_done 0, sdram_data_rc2cpu 0 at the next edge.
REQ-032 Reset mid-BUSY or mid-REFRESH SHALL abandon the operation with no sdram_done pulse; an aborted write SHALL NOT modify the array.
REQ-033 Array contents SHALL NOT be cleared by reset.
REQ-034 sdram_ready SHALL be 1 in the first cycle after reset releases.

Verification
REQ-035 LATENCY=2: write 0xDEADBEEF to addr 0x000123 accepted cycle T -> done=1 only at T+2, ready=0 at T+1..T+2, ready=1 at T+3; read 0x000123 -> rc2cpu=0xDEADBEEF during its done.
REQ-036 ADDR_BITS=14: write 0x11111111 to 0x004005, read 0x000005 -> 0x11111111 (alias); subsequent write leaves rc2cpu unchanged.
REQ-037 REFRESH_INTERVAL=16, REFRESH_CYCLES=4, req held low -> ready low exactly 4 cycles after each wrap (cycles 16..19, 32..35 post-reset).
REQ-038 Request accepted on cycle 15 with REFRESH_INTERVAL=16, LATENCY=3 -> done at 18, REFRESH 19..22, next request accepted no earlier than 23.
REQ-039 reset=0 asserted cycle T+1 during LATENCY=4 write -> no done pulse, array word unchanged, ready=1 after release.
REQ-040 LATENCY=1, sdram_req held high with alternating addresses -> done every second cycle, one per accepted request, no drops.

Source files
------------

// File: rtl/sdram_responder.sv
// Behavioural SDRAM stand-in: single outstanding request, fixed completion latency,
// periodic refresh bursts that block new requests while IDLE.
module sdram_responder #(
  parameter int ADDR_BITS        = 14,
  parameter int LATENCY          = 2,
  parameter int REFRESH_INTERVAL = 780,
  parameter int REFRESH_CYCLES   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sdram_req,
  input  logic        sdram_write,
  input  logic [21:0] sdram_addr,
  input  logic [31:0] sdram_data_cpu2rc,
  output logic        sdram_ready,
  output logic        sdram_done,
  output logic [31:0] sdram_data_rc2cpu
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE, REFRESH} state_e;

  localparam int RW = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [RW-1:0]          rcnt_q, rcnt_d;
  logic                   pend_q, pend_d;
  logic [ADDR_BITS-1:0]   addr_q;
  logic                   wr_q;
  logic [31:0]            wdata_q, rdata_q;
  logic [31:0]            mem [2**ADDR_BITS];

  logic                   accept, wrap, enter_done;
  logic [ADDR_BITS-1:0]   op_addr;
  logic                   op_wr;
  logic [31:0]            op_data;
  logic                   unused_addr;

  assign unused_addr = ^sdram_addr;

  assign sdram_ready       = (state_q == IDLE) && !pend_q;
  assign sdram_done        = (state_q == DONE);
  assign sdram_data_rc2cpu = rdata_q;
  assign accept            = sdram_req && sdram_ready;
  assign wrap              = (REFRESH_INTERVAL != 0) && (rcnt_q == RW'(REFRESH_INTERVAL - 1));

  // With LATENCY=1 DONE is entered on the accepting edge, so use the live inputs.
  assign op_addr    = (state_q == IDLE) ? sdram_addr[ADDR_BITS-1:0] : addr_q;
  assign op_wr      = (state_q == IDLE) ? sdram_write : wr_q;
  assign op_data    = (state_q == IDLE) ? sdram_data_cpu2rc : wdata_q;
  assign enter_done = (state_d == DONE) && (state_q != DONE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q | wrap;
    rcnt_d  = (wrap || REFRESH_INTERVAL == 0) ? '0 : rcnt_q + 1'b1;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) state_d = DONE;
          else begin
            state_d = BUSY;
            cnt_d   = 4'(LATENCY - 1);
          end
        end else if (pend_q || wrap) begin
          state_d = REFRESH;
          cnt_d   = 4'(REFRESH_CYCLES - 1);
          pend_d  = 1'b0;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd1) begin
          state_d = DONE;
          cnt_d   = '0;
        end else cnt_d = cnt_q - 1'b1;
      end
      DONE: begin
        // A refresh that came due during the access runs before the next request.
        if (pend_q || wrap) begin
          state_d = REFRESH;
          cnt_d   = 4'(REFRESH_CYCLES - 1);
          pend_d  = 1'b0;
        end else state_d = IDLE;
      end
      REFRESH: begin
        if (cnt_q == '0) state_d = IDLE;
        else cnt_d = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rcnt_q  <= '0;
      pend_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rcnt_q  <= rcnt_d;
      pend_q  <= pend_d;
      if (enter_done && !op_wr) rdata_q <= mem[op_addr];
      if (accept) begin
        addr_q  <= sdram_addr[ADDR_BITS-1:0];
        wr_q    <= sdram_write;
        wdata_q <= sdram_data_cpu2rc;
      end
    end
  end

  // Array is never cleared; a reset on the completing edge suppresses the write.
  always_ff @(posedge clk) begin
    if (reset && enter_done && op_wr) mem[op_addr] <= op_data;
  end

endmodule

// File: tb/tb_sdram_responder.sv
// Scoreboard bench: three responder configurations exercised in turn; stimulus pushes
// expected completions/levels, a single negedge monitor pops and compares.
module tb_sdram_responder;

  typedef struct {
    int          d;
    int          cyc;
    bit          rd;
    logic [31:0] data;
  } done_t;

  typedef struct {
    int          d;
    int          kind;   // 0 ready, 1 read data, 2 done level
    logic [31:0] exp;
    string       nm;
  } chk_t;

  logic        clk;
  logic        rst;
  logic        req  [3];
  logic        wr   [3];
  logic [21:0] addr [3];
  logic [31:0] wd   [3];
  logic        rdy  [3];
  logic        done [3];
  logic [31:0] rd   [3];

  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  bit    fin = 0;
  done_t dq[$];
  chk_t  cq[$];

  sdram_responder #(.LATENCY(2), .REFRESH_INTERVAL(0)) u_a (
    .clk(clk), .reset(rst), .sdram_req(req[0]), .sdram_write(wr[0]), .sdram_addr(addr[0]),
    .sdram_data_cpu2rc(wd[0]), .sdram_ready(rdy[0]), .sdram_done(done[0]),
    .sdram_data_rc2cpu(rd[0]));

  sdram_responder #(.LATENCY(3), .REFRESH_INTERVAL(16), .REFRESH_CYCLES(4)) u_b (
    .clk(clk), .reset(rst), .sdram_req(req[1]), .sdram_write(wr[1]), .sdram_addr(addr[1]),
    .sdram_data_cpu2rc(wd[1]), .sdram_ready(rdy[1]), .sdram_done(done[1]),
    .sdram_data_rc2cpu(rd[1]));

  sdram_responder #(.LATENCY(1), .REFRESH_INTERVAL(0)) u_c (
    .clk(clk), .reset(rst), .sdram_req(req[2]), .sdram_write(wr[2]), .sdram_addr(addr[2]),
    .sdram_data_cpu2rc(wd[2]), .sdram_ready(rdy[2]), .sdram_done(done[2]),
    .sdram_data_rc2cpu(rd[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: cycle %0d got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Monitor: the only process that compares or counts.
  always @(negedge clk) begin
    while (cq.size() != 0) begin
      chk_t c;
      logic [31:0] act;
      c = cq.pop_front();
      case (c.kind)
        0:       act = {31'b0, rdy[c.d]};
        1:       act = rd[c.d];
        default: act = {31'b0, done[c.d]};
      endcase
      check(c.nm, act, c.exp);
    end
    for (int d = 0; d < 3; d++) begin
      if (done[d] === 1'b1) begin
        if (dq.size() == 0) check("unexpected_done", d, 32'hFFFF_FFFF);
        else begin
          done_t e;
          e = dq.pop_front();
          check("done_dut", d, e.d);
          check("done_cycle", cyc, e.cyc);
          if (e.rd) check("read_data", rd[d], e.data);
        end
      end
    end
    if (fin) begin
      check("missing_done", dq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_lvl(input int d, input int kind, input logic [31:0] e, input string nm);
    cq.push_back('{d, kind, e, nm});
  endtask

  task automatic do_reset;
    rst = 1'b0;
    repeat (3) tick;
    rst = 1'b1;
  endtask

  // Issue one request once ready; returns one cycle after acceptance.
  task automatic op(input int d, input bit w, input logic [21:0] a, input logic [31:0] data,
                    input logic [31:0] exp, input int lat, input bit want_done);
    int n = 0;
    while (!rdy[d] && n < 100) begin
      tick;
      n++;
    end
    if (!rdy[d]) expect_lvl(d, 0, 1, "op_ready_timeout");
    req[d] = 1'b1; wr[d] = w; addr[d] = a; wd[d] = data;
    if (want_done) dq.push_back('{d, cyc + lat, !w, exp});
    tick;
    req[d] = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req[i] = 0; wr[i] = 0; addr[i] = '0; wd[i] = '0;
    end

    // ---- DUT A: LATENCY=2, no refresh ----
    do_reset;
    expect_lvl(0, 0, 1, "a_ready_after_reset");
    expect_lvl(0, 2, 0, "a_done_reset");
    expect_lvl(0, 1, 0, "a_rdata_reset");
    op(0, 1, 22'h000123, 32'hDEADBEEF, 0, 2, 1);
    expect_lvl(0, 0, 0, "a_ready_T1");
    tick; expect_lvl(0, 0, 0, "a_ready_T2");
    tick; expect_lvl(0, 0, 1, "a_ready_T3");
    op(0, 0, 22'h000123, 0, 32'hDEADBEEF, 2, 1);
    op(0, 1, 22'h004005, 32'h11111111, 0, 2, 1);
    op(0, 0, 22'h000005, 0, 32'h11111111, 2, 1);
    op(0, 1, 22'h000005, 32'h22222222, 0, 2, 1);
    tick; tick;
    expect_lvl(0, 1, 32'h11111111, "a_rdata_hold_after_write");
    op(0, 0, 22'h004005, 0, 32'h22222222, 2, 1);
    tick; tick;
    // Request held high through DONE: second acceptance the cycle after DONE.
    expect_lvl(0, 0, 1, "a_hold_ready");
    req[0] = 1'b1; wr[0] = 1'b0; addr[0] = 22'h000123;
    dq.push_back('{0, cyc + 2, 1'b1, 32'hDEADBEEF});
    dq.push_back('{0, cyc + 5, 1'b1, 32'hDEADBEEF});
    repeat (4) tick;
    req[0] = 1'b0;
    tick; tick;
    // Reset during a write: no done, array untouched, read data cleared.
    op(0, 1, 22'h000123, 32'hCAFEF00D, 0, 2, 0);
    do_reset;
    expect_lvl(0, 0, 1, "a_ready_after_abort");
    expect_lvl(0, 1, 0, "a_rdata_after_abort");
    op(0, 0, 22'h000123, 0, 32'hDEADBEEF, 2, 1);
    tick; tick; tick;

    // ---- DUT B: refresh every 16 cycles, 4-cycle burst ----
    do_reset;
    for (int i = 0; i < 40; i++) begin
      expect_lvl(1, 0, ((i >= 16 && i <= 19) || (i >= 32 && i <= 35)) ? 0 : 1, "b_refresh_ready");
      tick;
    end
    do_reset;
    repeat (15) tick;
    req[1] = 1'b1; wr[1] = 1'b1; addr[1] = 22'h7; wd[1] = 32'hA5A5A5A5;
    expect_lvl(1, 0, 1, "b_ready_cycle15");
    dq.push_back('{1, cyc + 3, 1'b0, 32'h0});
    dq.push_back('{1, cyc + 11, 1'b0, 32'h0});
    for (int i = 16; i <= 23; i++) begin
      tick;
      expect_lvl(1, 0, (i == 23) ? 1 : 0, "b_deferred_refresh_ready");
    end
    tick;
    req[1] = 1'b0;
    op(1, 0, 22'h7, 0, 32'hA5A5A5A5, 3, 1);
    tick; tick; tick;

    // ---- DUT C: LATENCY=1, back-to-back held request ----
    do_reset;
    op(2, 1, 22'h1, 32'h00000001, 0, 1, 1);
    op(2, 1, 22'h2, 32'h00000002, 0, 1, 1);
    tick;
    req[2] = 1'b1; wr[2] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      addr[2] = (k % 2 == 1) ? 22'h2 : 22'h1;
      dq.push_back('{2, cyc + 1, 1'b1, (k % 2 == 1) ? 32'h2 : 32'h1});
      expect_lvl(2, 0, 1, "c_ready_accept");
      tick;
      expect_lvl(2, 0, 0, "c_ready_done");
      tick;
    end
    req[2] = 1'b0;
    tick; tick;
    fin = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
